event_pulse_stretcher: RTL and testbench

EVENT_PULSE_STRETCHER -- requirements
Module: event_pulse_stretcher

---
 rtl/event_pulse_stretcher.sv | 147 ++++++++++++++
 tb/tb_event_pulse_stretcher.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_pulse_stretcher.sv
// Per-channel event pulse stretcher: each single-cycle event becomes a HOLD_CYCLES-wide
// registered pulse followed by a GAP_CYCLES forced-low gap. Define STRETCH_PEND_EN for a one-deep pending queue.
module event_pulse_stretcher #(
    parameter int NCH         = 5,
    parameter int HOLD_CYCLES = 130000,
    parameter int GAP_CYCLES  = 13000
) (
    input  logic           clk,
    input  logic           buttom_rst,
    input  logic [NCH-1:0] ev_pulse,
    output logic [NCH-1:0] level_out,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] ev_drop
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam bit HAS_GAP    = (GAP_CYCLES > 0);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = HAS_GAP ? CW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t         state_q [NCH];
    state_t         state_d [NCH];
    logic [CW-1:0]  cnt_q   [NCH];
    logic [CW-1:0]  cnt_d   [NCH];
    logic [NCH-1:0] level_d;
    logic [NCH-1:0] busy_d;
    logic [NCH-1:0] drop_d;
    logic           finish;
    logic           busy_ev;
`ifdef STRETCH_PEND_EN
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] pend_d;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = '0;
        level_d = '0;
        busy_d  = '0;
        finish  = 1'b0;
        busy_ev = 1'b0;
`ifdef STRETCH_PEND_EN
        pend_d  = pend_q;
`endif
        for (int i = 0; i < NCH; i++) begin
            finish  = 1'b0;
            busy_ev = 1'b0;
            unique case (state_q[i])
                ST_IDLE: begin
                    if (ev_pulse[i]) begin
                        state_d[i] = ST_HOLD;
                        cnt_d[i]   = HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                        busy_ev  = ev_pulse[i];
                    end else if (HAS_GAP) begin
                        state_d[i] = ST_GAP;
                        cnt_d[i]   = GAP_LOAD;
                        busy_ev    = ev_pulse[i];
                    end else begin
                        finish = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                        busy_ev  = ev_pulse[i];
                    end else begin
                        finish = 1'b1;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase

            // Final busy cycle: a fresh event or a queued one restarts HOLD with no extra idle cycle.
            if (finish) begin
`ifdef STRETCH_PEND_EN
                if (ev_pulse[i] || pend_q[i]) begin
                    state_d[i] = ST_HOLD;
                    cnt_d[i]   = HOLD_LOAD;
                    pend_d[i]  = ev_pulse[i] && pend_q[i];
                end else begin
                    state_d[i] = ST_IDLE;
                end
`else
                if (ev_pulse[i]) begin
                    state_d[i] = ST_HOLD;
                    cnt_d[i]   = HOLD_LOAD;
                end else begin
                    state_d[i] = ST_IDLE;
                end
`endif
            end

            if (busy_ev) begin
`ifdef STRETCH_PEND_EN
                if (pend_q[i]) drop_d[i] = 1'b1;
                else           pend_d[i] = 1'b1;
`else
                drop_d[i] = 1'b1;
`endif
            end

            level_d[i] = (state_d[i] == ST_HOLD);
            busy_d[i]  = (state_d[i] != ST_IDLE);
        end
    end

    // Outputs are flops loaded from the next state, so they never glitch and have no path from ev_pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (buttom_rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            level_out <= '0;
            busy      <= '0;
            ev_drop   <= '0;
`ifdef STRETCH_PEND_EN
            pend_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_out <= level_d;
            busy      <= busy_d;
            ev_drop   <= drop_d;
`ifdef STRETCH_PEND_EN
            pend_q    <= pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_event_pulse_stretcher.sv
// Self-checking bench for event_pulse_stretcher: directed scenarios plus randomized traffic
// compared each cycle against a timeline-based reference model.
module tb_event_pulse_stretcher;

    localparam int NCH = 5;
    localparam int H   = 4;
    localparam int G   = 2;
`ifdef STRETCH_PEND_EN
    localparam bit PEND_EN = 1'b1;
`else
    localparam bit PEND_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           buttom_rst;
    logic [NCH-1:0] ev_pulse;
    logic [NCH-1:0] level_out;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] ev_drop;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: first HOLD cycle of each channel's latest pulse, plus a pending flag.
    int             start_m [NCH];
    bit             pend_m  [NCH];
    logic [NCH-1:0] drop_m;

    event_pulse_stretcher #(
        .NCH         (NCH),
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G)
    ) dut (
        .clk        (clk),
        .buttom_rst (buttom_rst),
        .ev_pulse   (ev_pulse),
        .level_out  (level_out),
        .busy       (busy),
        .ev_drop    (ev_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [NCH-1:0] exp_level(input int c);
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = (c - start_m[i] >= 0) && (c - start_m[i] < H);
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_busy(input int c);
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = (c - start_m[i] >= 0) && (c - start_m[i] < H + G);
        return r;
    endfunction

    task automatic model_edge(input logic [NCH-1:0] ev, input logic rst);
        int p;
        drop_m = '0;
        for (int i = 0; i < NCH; i++) begin
            p = cyc - start_m[i];
            if (rst) begin
                start_m[i] = -100;
                pend_m[i]  = 1'b0;
            end else if (p < 0 || p >= H + G - 1) begin
                if (ev[i]) begin
                    start_m[i] = cyc + 1;
                end else if (pend_m[i] && p == H + G - 1) begin
                    start_m[i] = cyc + 1;
                    pend_m[i]  = 1'b0;
                end
            end else if (ev[i]) begin
                if (PEND_EN && !pend_m[i]) pend_m[i] = 1'b1;
                else                       drop_m[i] = 1'b1;
            end
        end
    endtask

    // Drive one cycle, advance the model at the edge, compare all outputs against it at the negedge.
    task automatic step(input logic [NCH-1:0] ev, input logic rst);
        ev_pulse   = ev;
        buttom_rst = rst;
        @(posedge clk);
        model_edge(ev, rst);
        cyc++;
        @(negedge clk);
        checks += 3;
        if (level_out !== exp_level(cyc)) begin
            errors++;
            $display("FAIL model_level cyc=%0d got=%b exp=%b", cyc, level_out, exp_level(cyc));
        end
        if (busy !== exp_busy(cyc)) begin
            errors++;
            $display("FAIL model_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy(cyc));
        end
        if (ev_drop !== drop_m) begin
            errors++;
            $display("FAIL model_drop cyc=%0d got=%b exp=%b", cyc, ev_drop, drop_m);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(5'h1F, 1'b1);
            checks++;
            if ({level_out, busy, ev_drop} !== 15'h0) begin
                errors++;
                $display("FAIL reset_hold got=%b exp=0", {level_out, busy, ev_drop});
            end
        end
        for (int k = 0; k < 8; k++) begin
            step('0, 1'b0);
            checks++;
            if ({level_out, busy, ev_drop} !== 15'h0) begin
                errors++;
                $display("FAIL reset_release got=%b exp=0", {level_out, busy, ev_drop});
            end
        end
    endtask

    task automatic test_single();
        int c;
        for (int r = 0; r < 18; r++) begin
            step((r == 10) ? 5'b00001 : 5'b00000, 1'b0);
            c = r + 1;
            checks += 2;
            if (level_out[0] !== (c >= 11 && c <= 14)) begin
                errors++;
                $display("FAIL single_level c=%0d got=%b exp=%b", c, level_out[0], (c >= 11 && c <= 14));
            end
            if (busy[0] !== (c >= 11 && c <= 16)) begin
                errors++;
                $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy[0], (c >= 11 && c <= 16));
            end
        end
        idle(10);
    endtask

    task automatic test_mid_hold();
        int c;
        logic el, ed;
        for (int r = 0; r < 22; r++) begin
            step((r == 10 || r == 12) ? 5'b00100 : 5'b00000, 1'b0);
            c  = r + 1;
            el = (c >= 11 && c <= 14) || (PEND_EN && c >= 17 && c <= 20);
            ed = !PEND_EN && c == 13;
            checks += 2;
            if (level_out[2] !== el) begin
                errors++;
                $display("FAIL mid_hold_level c=%0d got=%b exp=%b", c, level_out[2], el);
            end
            if (ev_drop[2] !== ed) begin
                errors++;
                $display("FAIL mid_hold_drop c=%0d got=%b exp=%b", c, ev_drop[2], ed);
            end
        end
        idle(15);
    endtask

    task automatic test_overflow();
        int c;
        logic el, ed;
        for (int r = 0; r < 22; r++) begin
            step((r >= 10 && r <= 12) ? 5'b01000 : 5'b00000, 1'b0);
            c  = r + 1;
            el = (c >= 11 && c <= 14) || (PEND_EN && c >= 17 && c <= 20);
            ed = PEND_EN ? (c == 13) : (c == 12 || c == 13);
            checks += 2;
            if (level_out[3] !== el) begin
                errors++;
                $display("FAIL overflow_level c=%0d got=%b exp=%b", c, level_out[3], el);
            end
            if (ev_drop[3] !== ed) begin
                errors++;
                $display("FAIL overflow_drop c=%0d got=%b exp=%b", c, ev_drop[3], ed);
            end
        end
        idle(15);
    endtask

    task automatic test_boundary();
        int c;
        logic el;
        for (int r = 0; r < 22; r++) begin
            step((r == 10 || r == 16) ? 5'b00010 : 5'b00000, 1'b0);
            c  = r + 1;
            el = (c >= 11 && c <= 14) || (c >= 17 && c <= 20);
            checks += 2;
            if (level_out[1] !== el) begin
                errors++;
                $display("FAIL boundary_level c=%0d got=%b exp=%b", c, level_out[1], el);
            end
            if (ev_drop[1] !== 1'b0) begin
                errors++;
                $display("FAIL boundary_drop c=%0d got=%b exp=0", c, ev_drop[1]);
            end
        end
        idle(10);
    endtask

    task automatic test_reset_mid_hold();
        int c;
        for (int r = 0; r < 16; r++) begin
            step((r == 10) ? 5'b10000 : 5'b00000, r == 12);
            c = r + 1;
            checks += 2;
            if (level_out[4] !== (c >= 11 && c <= 12)) begin
                errors++;
                $display("FAIL reset_mid_level c=%0d got=%b exp=%b", c, level_out[4], (c >= 11 && c <= 12));
            end
            if (busy[4] !== (c >= 11 && c <= 12)) begin
                errors++;
                $display("FAIL reset_mid_busy c=%0d got=%b exp=%b", c, busy[4], (c >= 11 && c <= 12));
            end
        end
        idle(5);
    endtask

    task automatic test_back_to_back();
        int c;
        for (int r = 0; r < 10; r++) begin
            step((r == 2) ? 5'h1F : 5'h00, 1'b0);
            c = r + 1;
            checks += 2;
            if (level_out !== ((c >= 3 && c <= 6) ? 5'h1F : 5'h00)) begin
                errors++;
                $display("FAIL b2b_level c=%0d got=%b", c, level_out);
            end
            if (busy !== ((c >= 3 && c <= 8) ? 5'h1F : 5'h00)) begin
                errors++;
                $display("FAIL b2b_busy c=%0d got=%b", c, busy);
            end
        end
        idle(5);
    endtask

    task automatic test_random();
        logic [NCH-1:0] ev;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NCH; i++) ev[i] = ($urandom_range(3) == 0);
            step(ev, $urandom_range(49) == 0);
        end
        idle(15);
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            start_m[i] = -100;
            pend_m[i]  = 1'b0;
        end
        drop_m     = '0;
        ev_pulse   = '0;
        buttom_rst = 1'b1;
        test_reset();
        test_single();
        test_mid_hold();
        test_overflow();
        test_boundary();
        test_reset_mid_hold();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
